// File: rtl/input_port_buffer.sv
// Input port buffer for one port of the 5-port mesh router: flit FIFO, XY route
// computation on head flits and a wormhole request/transfer state machine.
// Optional macro INBUF_ERR_EN adds a write-side packet tracker and a sticky err output.
module input_port_buffer #(
  parameter int unsigned NR    = 5,
  parameter int unsigned FW    = 32,
  parameter int unsigned CW    = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned X_CUR = 0,
  parameter int unsigned Y_CUR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [FW-1:0] in_flit,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [NR-1:0] req,
  input  logic [NR-1:0] grt,
  output logic [FW-1:0] out_flit,
  output logic          out_valid,
  input  logic          out_ready
`ifdef INBUF_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam int unsigned P_LOCAL = 0;
  localparam int unsigned P_NORTH = 1;
  localparam int unsigned P_EAST  = 2;
  localparam int unsigned P_SOUTH = 3;
  localparam int unsigned P_WEST  = 4;

  localparam logic [1:0] T_HEAD     = 2'b10;
  localparam logic [1:0] T_TAIL     = 2'b01;
  localparam logic [1:0] T_HEADTAIL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t          state;
  logic [FW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            wr_en;
  logic            pop;
  logic            drop;
  logic            xfer;
  logic [FW-1:0]   front;
  logic [1:0]      front_type;
  logic [CW-1:0]   dx;
  logic [CW-1:0]   dy;
  logic [NR-1:0]   route;

  // FIFO status from the wrap-flagged pointers
  always_comb begin
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    empty = (wr_ptr == rd_ptr);
  end

  assign in_ready   = ~full;
  assign front      = mem[rd_ptr[AW-1:0]];
  assign out_flit   = front;
  assign front_type = front[FW-1 -: 2];
  assign dx         = front[2*CW-1:CW];
  assign dy         = front[CW-1:0];

  // XY dimension-order route of the flit at the FIFO head
  always_comb begin
    route = '0;
    if (dx > CW'(X_CUR))      route[P_EAST]  = 1'b1;
    else if (dx < CW'(X_CUR)) route[P_WEST]  = 1'b1;
    else if (dy > CW'(Y_CUR)) route[P_NORTH] = 1'b1;
    else if (dy < CW'(Y_CUR)) route[P_SOUTH] = 1'b1;
    else                      route[P_LOCAL] = 1'b1;
  end

  // Output handshake and pop sources: granted transfers and dropped stray flits
  always_comb begin
    out_valid = (state != S_IDLE) && (|(grt & req)) && !empty;
    xfer      = out_valid && out_ready;
    drop      = (state == S_IDLE) && !empty && !front_type[1];
    pop       = xfer || drop;
  end

`ifdef INBUF_ERR_EN
  logic       pkt_open;
  logic       bad;
  logic [1:0] in_type;

  assign in_type = in_flit[FW-1 -: 2];

  // A head must arrive with no packet open; body/tail only inside an open packet
  always_comb begin
    bad   = in_type[1] ? pkt_open : !pkt_open;
    wr_en = in_valid && in_ready && !bad;
  end

  // Write-side packet tracker and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_open <= 1'b0;
      err      <= 1'b0;
    end else if (in_valid && in_ready) begin
      if (bad)                   err      <= 1'b1;
      else if (in_type[1])       pkt_open <= (in_type == T_HEAD);
      else if (in_type == T_TAIL) pkt_open <= 1'b0;
    end
  end
`else
  assign wr_en = in_valid && in_ready;
`endif

  // FIFO storage, written only when an entry is accepted
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_flit;
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Wormhole FSM: request on head, hold through the packet, release after tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      req   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty && front_type[1]) begin
            req   <= route;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (xfer) begin
            if (front_type == T_HEADTAIL) begin
              req   <= '0;
              state <= S_IDLE;
            end else begin
              state <= S_XFER;
            end
          end
        end
        S_XFER: begin
          if (xfer && (front_type == T_TAIL)) begin
            req   <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          req   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer at router (1,1), DEPTH=4, with a flit scoreboard.
module tb_input_port_buffer;

  localparam int unsigned NR = 5;
  localparam int unsigned FW = 32;

  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HT   = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [NR-1:0] req;
  logic [NR-1:0] grt;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready;
`ifdef INBUF_ERR_EN
  logic          err;
`endif

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [FW-1:0] sb_q[$];
  logic [23:0]   pay = 24'h000100;

  input_port_buffer #(.NR(NR), .FW(FW), .CW(3), .DEPTH(4), .X_CUR(1), .Y_CUR(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .grt       (grt),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef INBUF_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [2:0] x, input logic [2:0] y);
    pay = pay + 24'd1;
    return {t, pay, x, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one flit for exactly this cycle; in_ready must be high
  task automatic send_now(input logic [FW-1:0] f, input bit expect_out);
    in_flit  = f;
    in_valid = 1'b1;
    if (expect_out) sb_q.push_back(f);
    @(negedge clk);
    chk("in_ready_send", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Drive one flit, holding it until accepted (bounded)
  task automatic send_wait(input logic [FW-1:0] f);
    bit ok;
    ok       = 1'b0;
    in_flit  = f;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_wait_accepted", 32'(ok), 32'd1);
    if (ok) sb_q.push_back(f);
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard: every transfer must match the oldest expected flit
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_transfer", out_flit, 32'hDEAD_BEEF);
      end else begin
        chk("out_flit", out_flit, sb_q.pop_front());
      end
    end
  end

  initial begin
    bit drained;
    rst_n     = 1'b0;
    in_flit   = '0;
    in_valid  = 1'b0;
    grt       = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef INBUF_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // HEADTAIL to (3,1): east, REQ at t+2, transfer at t+2, release at t+3
    grt       = 5'b00100;
    out_ready = 1'b1;
    send_now(mk(T_HT, 3'd3, 3'd1), 1'b1);
    @(negedge clk);
    chk("ht_req_t1", 32'(req), 32'd0);
    chk("ht_ov_t1", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("ht_req_t2", 32'(req), 32'b00100);
    chk("ht_ov_t2", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("ht_req_t3", 32'(req), 32'd0);
    chk("ht_ov_t3", 32'(out_valid), 32'd0);
    chk("ht_sb_empty", 32'(sb_q.size()), 32'd0);
    tick();

    // Fill the FIFO with a 4-flit packet while ungranted, then drain back to back
    grt = '0;
    send_now(mk(T_HEAD, 3'd2, 3'd0), 1'b1);
    send_now(mk(T_BODY, 3'd0, 3'd0), 1'b1);
    send_now(mk(T_BODY, 3'd0, 3'd0), 1'b1);
    send_now(mk(T_TAIL, 3'd0, 3'd0), 1'b1);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_req", 32'(req), 32'b00100);
    chk("full_ov_nogrant", 32'(out_valid), 32'd0);
    tick();
    grt = 5'b00100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_ov", 32'(out_valid), 32'd1);
      if (i == 1) chk("burst_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("burst_req_rel", 32'(req), 32'd0);
    chk("burst_ov_end", 32'(out_valid), 32'd0);
    chk("burst_sb_empty", 32'(sb_q.size()), 32'd0);
    tick();

    // Routing sweep from (1,1): local, north, south, west
    begin
      logic [2:0]    rx [4];
      logic [2:0]    ry [4];
      logic [NR-1:0] rexp [4];
      rx[0] = 3'd1; ry[0] = 3'd1; rexp[0] = 5'b00001;
      rx[1] = 3'd1; ry[1] = 3'd3; rexp[1] = 5'b00010;
      rx[2] = 3'd1; ry[2] = 3'd0; rexp[2] = 5'b01000;
      rx[3] = 3'd0; ry[3] = 3'd2; rexp[3] = 5'b10000;
      for (int i = 0; i < 4; i++) begin
        grt = '0;
        send_now(mk(T_HT, rx[i], ry[i]), 1'b1);
        tick();
        @(negedge clk);
        chk("route_req", 32'(req), 32'(rexp[i]));
        chk("route_ov_nogrant", 32'(out_valid), 32'd0);
        tick();
        grt = rexp[i];
        @(negedge clk);
        chk("route_ov_grant", 32'(out_valid), 32'd1);
        tick();
        grt = '0;
        @(negedge clk);
        chk("route_req_rel", 32'(req), 32'd0);
        tick();
      end
    end

    // Mid-packet grant loss and backpressure
    grt       = '0;
    out_ready = 1'b1;
    send_now(mk(T_HEAD, 3'd2, 3'd1), 1'b1);
    send_now(mk(T_BODY, 3'd0, 3'd0), 1'b1);
    send_now(mk(T_BODY, 3'd0, 3'd0), 1'b1);
    @(negedge clk);
    chk("mid_req", 32'(req), 32'b00100);
    tick();
    grt = 5'b00100;
    @(negedge clk);
    chk("mid_ov_on", 32'(out_valid), 32'd1);
    tick();
    grt = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_ov_nogrant", 32'(out_valid), 32'd0);
      chk("mid_req_held", 32'(req), 32'b00100);
      tick();
    end
    grt       = 5'b00100;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_ov_stall", 32'(out_valid), 32'd1);
      chk("mid_req_stall", 32'(req), 32'b00100);
      tick();
    end
    out_ready = 1'b1;
    send_wait(mk(T_BODY, 3'd0, 3'd0));
    send_wait(mk(T_TAIL, 3'd0, 3'd0));
    drained = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_drained", 32'(drained), 32'd1);
    tick();
    @(negedge clk);
    chk("mid_req_rel", 32'(req), 32'd0);
    tick();

    // Stray BODY with no open packet is discarded and never requests
    grt = 5'b00100;
    send_now(mk(T_BODY, 3'd2, 3'd2), 1'b0);
    tick();
    @(negedge clk);
    chk("stray_req", 32'(req), 32'd0);
    chk("stray_ov", 32'(out_valid), 32'd0);
`ifdef INBUF_ERR_EN
    chk("stray_err", 32'(err), 32'd1);
`endif
    tick();
    send_now(mk(T_HT, 3'd2, 3'd2), 1'b1);
    tick();
    @(negedge clk);
    chk("after_stray_req", 32'(req), 32'b00100);
    tick();
    @(negedge clk);
    chk("after_stray_sb", 32'(sb_q.size()), 32'd0);
`ifdef INBUF_ERR_EN
    chk("err_sticky", 32'(err), 32'd1);
`endif
    tick();

    // Reset clears the sticky state
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst2_req", 32'(req), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
`ifdef INBUF_ERR_EN
    chk("rst2_err", 32'(err), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
